// File: rtl/inst_rom_loader_pkg.sv
// Shared bus widths, fetch constants and loader state encoding for the loadable instruction ROM.
// Also holds the word-justification helper used by the byte assembler.
package inst_rom_loader_pkg;

  localparam int unsigned InstBusWidth     = 32;
  localparam int unsigned InstAddrBusWidth = 32;
  localparam int unsigned ByteWidth        = 8;
  localparam int unsigned ByteCntWidth     = 2;
  localparam int unsigned ShiftRegWidth    = 24;

  localparam logic [InstBusWidth-1:0] ZeroWord   = '0;
  localparam logic                    ChipEnable = 1'b1;

  typedef enum logic [1:0] {
    LdIdle = 2'd0,
    LdLoad = 2'd1,
    LdRun  = 2'd2
  } ld_state_e;

  // Bytes arrive MSB-first; a short final word is left-justified and zero-padded.
  // The shift is 8*(3-bcnt), and 3-bcnt is simply ~bcnt for a 2-bit count.
  function automatic logic [InstBusWidth-1:0] justify_word(
    input logic [ShiftRegWidth-1:0] sr,
    input logic [ByteWidth-1:0]     data,
    input logic [ByteCntWidth-1:0]  bcnt
  );
    logic [InstBusWidth-1:0] raw;
    logic [4:0]              shamt;
    raw   = {sr, data};
    shamt = {~bcnt, 3'b000};
    return raw << shamt;
  endfunction

endpackage

// File: rtl/inst_rom_loader_ram.sv
// Instruction word array: one synchronous write port, one asynchronous read port.
// Contents are never reset so stale words survive reloads.
module inst_rom_loader_ram #(
  parameter int unsigned AddrWidth = 10,
  parameter int unsigned DataWidth = 32
) (
  input  logic                 clk_i,
  input  logic                 we_i,
  input  logic [AddrWidth-1:0] waddr_i,
  input  logic [DataWidth-1:0] wdata_i,
  input  logic [AddrWidth-1:0] raddr_i,
  output logic [DataWidth-1:0] rdata_o
);

  localparam int unsigned Depth = 2 ** AddrWidth;

  logic [DataWidth-1:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/inst_rom_loader.sv
// Loadable instruction ROM: assembles a big-endian byte stream into words, holds the CPU in
// reset while loading, and serves zero-latency fetches once the program is in place.
module inst_rom_loader
  import inst_rom_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        rom_ce,
  input  logic [InstAddrBusWidth-1:0] rom_addr,
  output logic [InstBusWidth-1:0]     rom_inst,
  input  logic                        ld_start,
  input  logic                        ld_valid,
  input  logic [ByteWidth-1:0]        ld_data,
  input  logic                        ld_last,
  output logic                        ld_ready,
  output logic                        cpu_rst,
  output logic [ADDR_WIDTH:0]         word_count,
  output logic                        overflow
);

  ld_state_e                 state_q;
  logic [ADDR_WIDTH:0]       ptr_q;
  logic [ByteCntWidth-1:0]   bcnt_q;
  logic [ShiftRegWidth-1:0]  sr_q;
  logic                      overflow_q;
  logic                      ld_ready_q;
  logic                      cpu_rst_q;

  logic                      accept;
  logic                      word_done;
  logic                      full;
  logic                      mem_we;
  logic [InstBusWidth-1:0]   word_data;
  logic [InstBusWidth-1:0]   mem_rdata;
  logic                      addr_in_range;
  logic                      rom_hit;
  logic                      unused_addr_lsb;

  // ld_start takes priority, so a byte presented alongside it is never accepted.
  always_comb begin
    accept    = (state_q == LdLoad) && ld_ready_q && ld_valid && !ld_start;
    word_done = accept && ((bcnt_q == 2'd3) || ld_last);
    full      = ptr_q[ADDR_WIDTH];
    mem_we    = word_done && !full;
    word_data = justify_word(sr_q, ld_data, bcnt_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= LdIdle;
      cpu_rst_q  <= 1'b1;
      ld_ready_q <= 1'b0;
      ptr_q      <= '0;
      bcnt_q     <= '0;
      sr_q       <= '0;
      overflow_q <= 1'b0;
    end else if (ld_start) begin
      state_q    <= LdLoad;
      cpu_rst_q  <= 1'b1;
      ld_ready_q <= 1'b1;
      ptr_q      <= '0;
      bcnt_q     <= '0;
      sr_q       <= '0;
      overflow_q <= 1'b0;
    end else if (accept) begin
      if (word_done) begin
        bcnt_q <= '0;
        sr_q   <= '0;
        // Once ptr reaches DEPTH it parks there and further words only raise overflow.
        if (full) begin
          overflow_q <= 1'b1;
        end else begin
          ptr_q <= ptr_q + {{ADDR_WIDTH{1'b0}}, 1'b1};
        end
        if (ld_last) begin
          state_q    <= LdRun;
          cpu_rst_q  <= 1'b0;
          ld_ready_q <= 1'b0;
        end
      end else begin
        sr_q   <= {sr_q[ShiftRegWidth-ByteWidth-1:0], ld_data};
        bcnt_q <= bcnt_q + 2'd1;
      end
    end
  end

  inst_rom_loader_ram #(
    .AddrWidth (ADDR_WIDTH),
    .DataWidth (InstBusWidth)
  ) u_inst_ram (
    .clk_i   (clk),
    .we_i    (mem_we),
    .waddr_i (ptr_q[ADDR_WIDTH-1:0]),
    .wdata_i (word_data),
    .raddr_i (rom_addr[ADDR_WIDTH+1:2]),
    .rdata_o (mem_rdata)
  );

  // Fetch is purely combinational so the CPU sees the word in the same cycle as its pc.
  assign addr_in_range   = (rom_addr[InstAddrBusWidth-1:ADDR_WIDTH+2] == '0);
  assign rom_hit         = (state_q == LdRun) && (rom_ce == ChipEnable) && addr_in_range;
  assign rom_inst        = rom_hit ? mem_rdata : ZeroWord;
  assign unused_addr_lsb = ^rom_addr[1:0];

  assign ld_ready   = ld_ready_q;
  assign cpu_rst    = cpu_rst_q;
  assign word_count = ptr_q;
  assign overflow   = overflow_q;

endmodule
